// File: rtl/mul_add.sv
// mul_add: sequential shift-add multiply-accumulate, product = quotient*divisor + remainder.
// Mirrors the divider's start/done handshake, so the two can be paired for a round-trip check.
module mul_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     dividend,
    output logic                 overflow,
    output logic                 rem_invalid
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] mq;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            rem_inv_q;
    logic [PW-1:0]   acc_sum;

    // Accumulator value after the current iteration; also the final result on the last one.
    always_comb begin
        acc_sum = acc;
        if (mq[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // Control FSM, datapath iteration and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mq          <= '0;
            mcand       <= '0;
            acc         <= '0;
            cnt         <= '0;
            rem_inv_q   <= 1'b0;
            done        <= 1'b0;
            product     <= '0;
            dividend    <= '0;
            overflow    <= 1'b0;
            rem_invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mq        <= quotient;
                        mcand     <= {{WIDTH{1'b0}}, divisor};
                        acc       <= {{WIDTH{1'b0}}, remainder};
                        cnt       <= '0;
                        rem_inv_q <= (divisor != '0) && (remainder >= divisor);
                        state     <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mq    <= mq >> 1;
                    cnt   <= cnt + CW'(1);
                    // Fixed WIDTH iterations: latency never depends on the operands.
                    if (cnt == LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        product     <= acc_sum;
                        dividend    <= acc_sum[WIDTH-1:0];
                        overflow    <= |acc_sum[PW-1:WIDTH];
                        rem_invalid <= rem_inv_q;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add.sv
// Self-checking bench for mul_add against an arithmetic reference model.
module tb_mul_add;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] quotient;
    logic [31:0] divisor;
    logic [31:0] remainder;
    logic        done;
    logic [63:0] product;
    logic [31:0] dividend;
    logic        overflow;
    logic        rem_invalid;

    int errors;
    int checks;

    mul_add #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .quotient    (quotient),
        .divisor     (divisor),
        .remainder   (remainder),
        .done        (done),
        .product     (product),
        .dividend    (dividend),
        .overflow    (overflow),
        .rem_invalid (rem_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_product(logic [31:0] q, logic [31:0] d, logic [31:0] r);
        return 64'(q) * 64'(d) + 64'(r);
    endfunction

    function automatic logic ref_rem_invalid(logic [31:0] d, logic [31:0] r);
        return (d != 32'd0) && (r >= d);
    endfunction

    // Pulse start for one edge; operands are scrambled right after acceptance.
    task automatic do_start(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        @(negedge clk);
        quotient  = q;
        divisor   = d;
        remainder = r;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        quotient  = $urandom;
        divisor   = $urandom;
        remainder = $urandom;
    endtask

    // Count edges until done is seen; timed_out set if budget expires.
    task automatic wait_done(output int n, output bit timed_out);
        n = 0;
        timed_out = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        quotient = '0;
        divisor = '0;
        remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, product, dividend, overflow, rem_invalid} !== 99'd0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b product=%h dividend=%h ovf=%b ri=%b, want all 0",
                     done, product, dividend, overflow, rem_invalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        bit to;
        do_start(32'd1, 32'd7, 32'd3);
        wait_done(n, to);
        checks++;
        if (to || n != 32) begin
            errors++;
            $display("FAIL basic_latency: got %0d (timeout=%0b), want 32", n, to);
        end
        checks++;
        if (product !== 64'd10 || dividend !== 32'd10 || overflow !== 1'b0 || rem_invalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got product=%0d dividend=%0d ovf=%b ri=%b, want 10 10 0 0",
                     product, dividend, overflow, rem_invalid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
        checks++;
        if (product !== 64'd10) begin
            errors++;
            $display("FAIL basic_hold: product=%0d after done, want 10", product);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tq [3] = '{32'd1, 32'd14, 32'd0};
        logic [31:0] td [3] = '{32'd100, 32'd7, 32'd150};
        logic [31:0] tr [3] = '{32'd0, 32'd2, 32'd70};
        logic [63:0] exp_p;
        int n;
        bit to;
        for (int i = 0; i < 3; i++) begin
            do_start(tq[i], td[i], tr[i]);
            wait_done(n, to);
            exp_p = ref_product(tq[i], td[i], tr[i]);
            checks++;
            if (to || n != 32) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d edges after start (timeout=%0b), want 32", i, n, to);
            end
            checks++;
            if (product !== exp_p || dividend !== exp_p[31:0] || rem_invalid !== ref_rem_invalid(td[i], tr[i])) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got product=%0d dividend=%0d ri=%b, want %0d %0d %b",
                         i, product, dividend, rem_invalid, exp_p, exp_p[31:0], ref_rem_invalid(td[i], tr[i]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation checked fully against the model.
    task automatic check_op(input string name, input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        logic [63:0] exp_p;
        int n;
        bit to;
        exp_p = ref_product(q, d, r);
        do_start(q, d, r);
        wait_done(n, to);
        checks++;
        if (to || n != 32) begin
            errors++;
            $display("FAIL %s_latency: got %0d (timeout=%0b), want 32", name, n, to);
        end
        checks++;
        if (product !== exp_p || dividend !== exp_p[31:0] || overflow !== (exp_p[63:32] != 32'd0)
            || rem_invalid !== ref_rem_invalid(d, r)) begin
            errors++;
            $display("FAIL %s_result: q=%h d=%h r=%h got product=%h dividend=%h ovf=%b ri=%b, want %h %h %b %b",
                     name, q, d, r, product, dividend, overflow, rem_invalid,
                     exp_p, exp_p[31:0], exp_p[63:32] != 32'd0, ref_rem_invalid(d, r));
        end
    endtask

    task automatic test_max();
        check_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        checks++;
        if (product !== 64'hFFFF_FFFE_FFFF_FFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL max_const: got product=%h ovf=%b, want fffffffeffffffff 1", product, overflow);
        end
    endtask

    task automatic test_flags();
        check_op("flag_invalid", 32'd5, 32'd3, 32'd4);
        checks++;
        if (product !== 64'd19 || rem_invalid !== 1'b1) begin
            errors++;
            $display("FAIL flag_invalid_const: got product=%0d ri=%b, want 19 1", product, rem_invalid);
        end
        check_op("flag_div0", 32'd9, 32'd0, 32'd5);
        checks++;
        if (product !== 64'd5 || rem_invalid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flag_div0_const: got product=%0d ri=%b ovf=%b, want 5 0 0", product, rem_invalid, overflow);
        end
    endtask

    task automatic test_random();
        logic [31:0] q, d, r;
        for (int i = 0; i < 8; i++) begin
            q = $urandom;
            d = (i == 3) ? 32'd0 : $urandom;
            r = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 255));
            if (i == 5) q = 32'($urandom_range(0, 15));
            check_op("random", q, d, r);
        end
    endtask

    task automatic test_start_busy();
        int n;
        bit to;
        int extra;
        do_start(32'd2, 32'd2, 32'd0);
        repeat (9) @(posedge clk);
        do_start(32'd3, 32'd3, 32'd0);
        wait_done(n, to);
        checks++;
        if (to || n != 22) begin
            errors++;
            $display("FAIL busy_latency: done %0d edges after 2nd start (timeout=%0b), want 22", n, to);
        end
        checks++;
        if (product !== 64'd4) begin
            errors++;
            $display("FAIL busy_result: product=%0d, want 4", product);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_second_done: saw %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bit to;
        int extra;
        do_start(32'd6, 32'd6, 32'd1);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done, product, dividend, overflow, rem_invalid} !== 99'd0) begin
            errors++;
            $display("FAIL midreset_clear: got done=%b product=%h dividend=%h ovf=%b ri=%b, want all 0",
                     done, product, dividend, overflow, rem_invalid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midreset_no_done: saw %0d done pulses after reset, want 0", extra);
        end
        do_start(32'd6, 32'd6, 32'd1);
        wait_done(n, to);
        checks++;
        if (to || n != 32 || product !== 64'd37) begin
            errors++;
            $display("FAIL midreset_restart: latency=%0d timeout=%0b product=%0d, want 32 0 37", n, to, product);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_max();
        test_flags();
        test_random();
        test_start_busy();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
